// File: rtl/pmt_pulse_conditioner.sv
// PMT discriminator front end: synchronise, reject short glitches, enforce a
// non-paralysable dead time and emit a phase-tagged one-cycle count strobe.
module pmt_pulse_conditioner #(
  parameter int unsigned MIN_WIDTH = 2,
  parameter int unsigned DEAD_TIME = 10,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clock_50_mhz,
  input  logic             reset,
  input  logic             PMT_in,
  input  logic             light_source_flag,
  input  logic             clear_counts,
  output logic             pulse_strobe,
  output logic             pulse_phase,
  output logic             busy,
  output logic [CNT_W-1:0] glitch_count,
  output logic [CNT_W-1:0] pileup_count
);

  localparam int unsigned WW = 8;
  localparam int unsigned DW = 16;
  localparam logic [WW-1:0]    WIDTH_LAST = WW'(MIN_WIDTH - 1);
  localparam logic [DW-1:0]    DEAD_LAST  = DW'(DEAD_TIME - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  generate
    if (MIN_WIDTH == 0 || MIN_WIDTH > 255 || DEAD_TIME == 0 || DEAD_TIME > 65535 || CNT_W == 0)
    begin : g_bad_param
      $fatal(1, "pmt_pulse_conditioner: illegal MIN_WIDTH/DEAD_TIME/CNT_W");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, QUALIFY, DEAD, WAIT_LOW} state_e;

  logic             s1_q, pmt_s_q, pmt_prev_q;
  logic             rise_c;
  state_e           state_q;
  logic [WW-1:0]    width_cnt_q;
  logic [DW-1:0]    dead_cnt_q;
  logic             phase_l_q, strobe_q, phase_q, busy_q;
  logic             glitch_inc_c, pileup_inc_c;
  logic [CNT_W-1:0] glitch_q, glitch_d, pileup_q, pileup_d;

  // Two-flop synchroniser plus one-cycle history for rising-edge detection
  always_ff @(posedge clock_50_mhz or posedge reset) begin
    if (reset) begin
      s1_q       <= 1'b0;
      pmt_s_q    <= 1'b0;
      pmt_prev_q <= 1'b0;
    end else begin
      s1_q       <= PMT_in;
      pmt_s_q    <= s1_q;
      pmt_prev_q <= pmt_s_q;
    end
  end

  assign rise_c = pmt_s_q & ~pmt_prev_q;

  // Pulse qualification / dead-time sequencer with registered outputs
  always_ff @(posedge clock_50_mhz or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      width_cnt_q <= '0;
      dead_cnt_q  <= '0;
      phase_l_q   <= 1'b0;
      strobe_q    <= 1'b0;
      phase_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      strobe_q <= 1'b0;
      phase_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (pmt_s_q) begin
            phase_l_q   <= light_source_flag;
            width_cnt_q <= WW'(1);
            busy_q      <= 1'b1;
            if (MIN_WIDTH == 1) begin
              strobe_q   <= 1'b1;
              phase_q    <= light_source_flag;
              dead_cnt_q <= '0;
              state_q    <= DEAD;
            end else begin
              state_q <= QUALIFY;
            end
          end
        end
        QUALIFY: begin
          if (!pmt_s_q) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (width_cnt_q == WIDTH_LAST) begin
            strobe_q   <= 1'b1;
            phase_q    <= phase_l_q;
            dead_cnt_q <= '0;
            state_q    <= DEAD;
          end else begin
            width_cnt_q <= width_cnt_q + WW'(1);
          end
        end
        DEAD: begin
          dead_cnt_q <= dead_cnt_q + DW'(1);
          if (dead_cnt_q == DEAD_LAST) begin
            if (pmt_s_q) begin
              state_q <= WAIT_LOW;
            end else begin
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end
          end
        end
        WAIT_LOW: begin
          if (!pmt_s_q) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign glitch_inc_c = (state_q == QUALIFY) && !pmt_s_q;
  assign pileup_inc_c = (state_q == DEAD) && rise_c;

  // Saturating diagnostics; a coincident clear discards the increment
  always_comb begin
    glitch_d = glitch_q;
    pileup_d = pileup_q;
    if (clear_counts) begin
      glitch_d = '0;
      pileup_d = '0;
    end else begin
      if (glitch_inc_c && glitch_q != CNT_MAX) glitch_d = glitch_q + CNT_W'(1);
      if (pileup_inc_c && pileup_q != CNT_MAX) pileup_d = pileup_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock_50_mhz or posedge reset) begin
    if (reset) begin
      glitch_q <= '0;
      pileup_q <= '0;
    end else begin
      glitch_q <= glitch_d;
      pileup_q <= pileup_d;
    end
  end

  assign pulse_strobe = strobe_q;
  assign pulse_phase  = phase_q;
  assign busy         = busy_q;
  assign glitch_count = glitch_q;
  assign pileup_count = pileup_q;

endmodule

// File: tb/tb_pmt_pulse_conditioner.sv
// Bench for pmt_pulse_conditioner: two parameterisations driven by the same
// stimulus and compared every cycle against a deadline-based timeline model.
module tb_pmt_pulse_conditioner;

  localparam int unsigned MW_A = 2, DT_A = 10, CW_A = 4;
  localparam int unsigned MW_B = 1, DT_B = 3,  CW_B = 16;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic pmt   = 1'b0;
  logic flag  = 1'b0;
  logic clr   = 1'b0;

  logic            str_a, ph_a, bsy_a, str_b, ph_b, bsy_b;
  logic [CW_A-1:0] gl_a, pl_a;
  logic [CW_B-1:0] gl_b, pl_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pmt_pulse_conditioner #(.MIN_WIDTH(MW_A), .DEAD_TIME(DT_A), .CNT_W(CW_A)) dut_a (
    .clock_50_mhz(clk), .reset(reset), .PMT_in(pmt), .light_source_flag(flag),
    .clear_counts(clr), .pulse_strobe(str_a), .pulse_phase(ph_a), .busy(bsy_a),
    .glitch_count(gl_a), .pileup_count(pl_a));

  pmt_pulse_conditioner #(.MIN_WIDTH(MW_B), .DEAD_TIME(DT_B), .CNT_W(CW_B)) dut_b (
    .clock_50_mhz(clk), .reset(reset), .PMT_in(pmt), .light_source_flag(flag),
    .clear_counts(clr), .pulse_strobe(str_b), .pulse_phase(ph_b), .busy(bsy_b),
    .glitch_count(gl_b), .pileup_count(pl_b));

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %0d expected %0d at %0t", nm, i, act, exp, $time);
    end
  endtask

  function automatic longint mwf(int i); return (i == 0) ? longint'(MW_A) : longint'(MW_B); endfunction
  function automatic longint dtf(int i); return (i == 0) ? longint'(DT_A) : longint'(DT_B); endfunction
  function automatic int cmaxf(int i); return (i == 0) ? 15 : 65535; endfunction

  // Model: synchronised level history, a candidate pulse start, a dead-time
  // deadline and a "must see low" flag per instance.
  bit     ms1 = 0, ms = 0, mprev = 0;
  longint cyc = 0;
  bit     cand [2];
  longint cand_start [2];
  bit     cand_ph [2];
  longint dead_until [2] = '{-1, -1};
  bit     need_low [2];
  int     e_gl [2], e_pl [2], msc [2];
  bit     e_str [2], e_ph [2], e_busy [2];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      ms1 = 0; ms = 0; mprev = 0; cyc = 0;
      for (int i = 0; i < 2; i++) begin
        cand[i] = 0; dead_until[i] = -1; need_low[i] = 0;
        e_gl[i] = 0; e_pl[i] = 0; e_str[i] = 0; e_ph[i] = 0; e_busy[i] = 0;
      end
    end else begin
      bit rise;
      cyc++;
      rise = ms & !mprev;
      for (int i = 0; i < 2; i++) begin
        bit ginc, pinc;
        ginc = 0; pinc = 0; e_str[i] = 0; e_ph[i] = 0;
        if (cyc <= dead_until[i]) begin
          if (rise) pinc = 1;
          if (cyc == dead_until[i] && ms) need_low[i] = 1;
        end else if (need_low[i]) begin
          if (!ms) need_low[i] = 0;
        end else if (ms) begin
          if (!cand[i]) begin
            cand[i] = 1; cand_start[i] = cyc; cand_ph[i] = flag;
          end
          if (cyc - cand_start[i] + 1 == mwf(i)) begin
            e_str[i] = 1; e_ph[i] = cand_ph[i]; msc[i]++;
            dead_until[i] = cyc + dtf(i); cand[i] = 0;
          end
        end else if (cand[i]) begin
          ginc = 1; cand[i] = 0;
        end
        if (clr) begin
          e_gl[i] = 0; e_pl[i] = 0;
        end else begin
          if (ginc && e_gl[i] < cmaxf(i)) e_gl[i]++;
          if (pinc && e_pl[i] < cmaxf(i)) e_pl[i]++;
        end
        e_busy[i] = cand[i] || (dead_until[i] >= cyc + 1) || need_low[i];
      end
      mprev = ms; ms = ms1; ms1 = pmt;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    chk("strobe", 0, 32'(str_a), 32'(e_str[0]));
    chk("phase",  0, 32'(ph_a),  32'(e_ph[0]));
    chk("busy",   0, 32'(bsy_a), 32'(e_busy[0]));
    chk("glitch", 0, 32'(gl_a),  32'(e_gl[0]));
    chk("pileup", 0, 32'(pl_a),  32'(e_pl[0]));
    chk("strobe", 1, 32'(str_b), 32'(e_str[1]));
    chk("phase",  1, 32'(ph_b),  32'(e_ph[1]));
    chk("busy",   1, 32'(bsy_b), 32'(e_busy[1]));
    chk("glitch", 1, 32'(gl_b),  32'(e_gl[1]));
    chk("pileup", 1, 32'(pl_b),  32'(e_pl[1]));
  end

  int ncyc = 0;
  int sc_a = 0, sc_b = 0, last_n_a = 0, last_n_b = 0;
  logic last_ph_a = 0, last_ph_b = 0;

  always @(negedge clk) begin
    ncyc++;
    if (str_a === 1'b1) begin sc_a++; last_n_a = ncyc; last_ph_a = ph_a; end
    if (str_b === 1'b1) begin sc_b++; last_n_b = ncyc; last_ph_b = ph_b; end
  end

  task automatic tick(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic pulse(input int hi, input int lo);
    pmt = 1'b1; tick(hi);
    pmt = 1'b0; tick(lo);
  endtask

  initial begin
    int j0, len;
    tick(3);
    chk("rst_strobe", 0, 32'(str_a), 0);
    chk("rst_busy",   0, 32'(bsy_a), 0);
    chk("rst_glitch", 0, 32'(gl_a),  0);
    reset = 1'b0;
    tick(3);

    // Basic accept with phase 1
    flag = 1'b1;
    pmt = 1'b1; j0 = ncyc;
    tick(4);
    chk("t1_strobe_at_N2", 0, 32'(str_a), 1);
    chk("t1_busy", 0, 32'(bsy_a), 1);
    tick(1); pmt = 1'b0; tick(15);
    chk("t1_count", 0, 32'(sc_a), 1);
    chk("t1_latency", 0, 32'(last_n_a - j0), 4);
    chk("t1_phase", 0, 32'(last_ph_a), 1);
    chk("t1_count", 1, 32'(sc_b), 1);
    chk("t1_latency", 1, 32'(last_n_b - j0), 3);
    chk("t1_idle", 0, 32'(bsy_a), 0);
    chk("t1_pileup", 0, 32'(pl_a), 0);

    // Pile-up inside dead time, then a pulse after it expires
    pulse(3, 2); pulse(3, 12); pulse(3, 15);
    chk("t3_count", 0, 32'(sc_a), 3);
    chk("t3_pileup", 0, 32'(pl_a), 1);

    // Long pulse counted once, then a short one after a single low cycle
    pmt = 1'b1; tick(40);
    chk("t4_waitlow_busy", 0, 32'(bsy_a), 1);
    chk("t4_count_once", 0, 32'(sc_a), 4);
    pmt = 1'b0; tick(1);
    pulse(3, 15);
    chk("t4_count_after", 0, 32'(sc_a), 5);
    chk("t4_pileup", 0, 32'(pl_a), 1);

    // Glitches with both phases
    pulse(1, 4);
    chk("t2_glitch1", 0, 32'(gl_a), 1);
    chk("t2_no_strobe", 0, 32'(sc_a), 5);
    flag = 1'b0;
    pulse(1, 4);
    chk("t2_glitch2", 0, 32'(gl_a), 2);

    // Saturation, then clear coinciding with glitch detection
    repeat (20) pulse(1, 4);
    chk("t5_saturate", 0, 32'(gl_a), 15);
    pmt = 1'b1; tick(1);
    pmt = 1'b0; tick(2);
    clr = 1'b1; tick(1);
    clr = 1'b0;
    chk("t5_clear_wins", 0, 32'(gl_a), 0);
    chk("t5_clear_pileup", 0, 32'(pl_a), 0);
    tick(4);

    // Asynchronous reset in the middle of dead time
    flag = 1'b1;
    pulse(3, 1);
    chk("t6_strobe", 0, 32'(str_a), 1);
    tick(2);
    #2 reset = 1'b1;
    #1;
    chk("t6_async_strobe", 0, 32'(str_a), 0);
    chk("t6_async_busy",   0, 32'(bsy_a), 0);
    chk("t6_async_busy",   1, 32'(bsy_b), 0);
    chk("t6_async_pileup", 0, 32'(pl_a),  0);
    tick(2);
    reset = 1'b0;
    tick(2);
    len = sc_a;
    pmt = 1'b1; j0 = ncyc;
    tick(3); pmt = 1'b0; tick(1);
    chk("t6_strobe_after", 0, 32'(str_a), 1);
    tick(12);
    chk("t6_count", 0, 32'(sc_a - len), 1);
    chk("t6_latency", 0, 32'(last_n_a - j0), 4);

    // Randomised pulse trains
    for (int k = 0; k < 160; k++) begin
      pmt = ~pmt;
      len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(5, 20)) : int'($urandom_range(1, 4));
      repeat (len) begin
        flag = 1'($urandom_range(0, 1));
        clr  = ($urandom_range(0, 29) == 0);
        tick(1);
      end
      if (k == 80) begin
        reset = 1'b1; tick(2); reset = 1'b0;
      end
    end
    pmt = 1'b0; clr = 1'b0;
    tick(30);
    chk("total_strobes", 0, 32'(sc_a), 32'(msc[0]));
    chk("total_strobes", 1, 32'(sc_b), 32'(msc[1]));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pmt_pulse_conditioner.md
Name: pmt_pulse_conditioner

Overview:
Front-end stage that directly feeds the photon-counting integrator.
- Takes the raw, asynchronous PMT discriminator output and synchronises it to clock_50_mhz.
- Rejects glitches shorter than a minimum width and enforces a non-paralysable dead time.
- Emits a one-cycle count strobe tagged with the light-source phase in effect when the pulse arrived.
- Keeps saturating diagnostic counters of rejected glitches and pile-up events.

Parameters:
MIN_WIDTH, 2, synchronised high cycles required to accept a pulse; legal range 1..255
DEAD_TIME, 10, cycles after acceptance during which new pulses are not counted; legal range 1..65535
CNT_W, 16, width of the glitch and pile-up counters

Ports:
clock_50_mhz  in  1  system clock, 50 MHz
reset  in  1  asynchronous, active-high reset
PMT_in  in  1  raw PMT discriminator output, asynchronous to clock_50_mhz
light_source_flag  in  1  light modulation phase, synchronous to clock_50_mhz
clear_counts  in  1  synchronous clear of both diagnostic counters
pulse_strobe  out  1  one-cycle pulse for each accepted photon
pulse_phase  out  1  light phase of that photon; valid only while pulse_strobe=1
busy  out  1  high whenever state != IDLE
glitch_count  out  CNT_W  saturating count of rejected short pulses
pileup_count  out  CNT_W  saturating count of rising edges seen during dead time

Behaviour:
- Clock and reset: one clock domain. Reset is asynchronous and active-high.
- Reset values: all outputs 0, both synchroniser flops 0, pmt_prev 0, state IDLE, internal counters 0. Reset wins over every other input at any time, including mid-DEAD.
- Synchroniser: 2-flop chain PMT_in -> s1 -> pmt_s. pmt_prev is pmt_s delayed one cycle. rise = pmt_s & ~pmt_prev. No logic acts on s1.
- Timing reference: let N be the first cycle with pmt_s=1.
- IDLE:
  - If pmt_s=1: latch phase_l <= light_source_flag (sampled in cycle N) and width_cnt <= 1.
  - If MIN_WIDTH=1: accept immediately, go to DEAD. Otherwise go to QUALIFY.
- QUALIFY:
  - If pmt_s=0: glitch_count +1 (saturating), go to IDLE.
  - Else if width_cnt = MIN_WIDTH-1: accept, go to DEAD.
  - Else width_cnt +1.
- Accept action: registered pulse_strobe <= 1 and pulse_phase <= phase_l; dead_cnt <= 0.
  - pulse_strobe is high for exactly one cycle, cycle N+MIN_WIDTH.
  - Latency from the PMT_in edge is therefore MIN_WIDTH+2 to MIN_WIDTH+3 clocks.
  - pulse_phase returns to 0 when pulse_strobe drops.
- DEAD:
  - dead_cnt +1 every cycle.
  - Each rise seen in DEAD: pileup_count +1 (saturating). Pile-up pulses never produce a strobe and never extend the dead time.
  - When dead_cnt = DEAD_TIME-1: go to IDLE if pmt_s=0, else go to WAIT_LOW.
- WAIT_LOW: stay while pmt_s=1; go to IDLE on pmt_s=0. A long pulse is counted exactly once.
- Re-arm: the earliest new acceptance is the cycle after returning to IDLE with pmt_s=1. A new rise in that IDLE cycle is a fresh pulse.
- Counters:
  - Width CNT_W; saturate at all-ones and never wrap.
  - clear_counts=1 zeroes both counters in the next cycle. If clear and increment coincide, clear wins and the increment is lost.
  - Counters are independent of strobe generation.
- Reset release during a pulse: if PMT_in is still high after release, it propagates through the synchroniser. It is treated as a new pulse and accepted if it meets MIN_WIDTH.
- Illegal parameters (MIN_WIDTH=0, DEAD_TIME=0) are not supported. An elaboration-time check halts the build.

Test Plan:
1. Basic accept (defaults, light_source_flag=1, PMT_in high 5 cycles) -> exactly one pulse_strobe in cycle N+2 with pulse_phase=1; busy high from N+1 until DEAD/WAIT_LOW ends; both counters remain 0.
2. Glitch (PMT_in high 1 clock, aligned to clock edge) -> no strobe; glitch_count=1; state back in IDLE 2 cycles after pmt_s rises; repeat with light_source_flag=0 -> glitch_count=2.
3. Pile-up (two 3-cycle pulses whose rises are 5 cycles apart, DEAD_TIME=10) -> one strobe, pileup_count=1. A third pulse rising 20 cycles after the first -> second strobe, pileup_count stays 1.
4. Long pulse (PMT_in high 40 cycles) -> one strobe, then WAIT_LOW until pmt_s falls. A following 3-cycle pulse after ≥1 low cycle -> one strobe.
5. Saturation and clear (CNT_W=4, 20 glitches) -> glitch_count=15 and holds. clear_counts asserted in the same cycle as a 21st glitch detection -> glitch_count=0 next cycle.
6. Reset mid-DEAD (assert reset asynchronously 3 cycles after a strobe) -> all outputs 0 immediately without a clock edge; after release with PMT_in low -> IDLE, and a 3-cycle pulse yields a strobe in cycle N+2.
